// File: rtl/writeback_ctrl_pkg.sv
// Shared CPU definitions for the register-file write side: widths and the
// buffered long-latency result entry.
package writeback_ctrl_pkg;

  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 1 << REG_W;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for long-latency results; power-of-two depth so the
// pointers wrap naturally, occupancy counter runs 0..DEPTH.
module wb_fifo
  import writeback_ctrl_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = wb_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  T                       i_data,
  input  logic                   i_pop,
  output T                       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  T                 r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define what is
  // valid, and leaving the array out of reset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/writeback_ctrl.sv
// Register-file write port owner: arbitrates ALU results over buffered
// long-latency results and keeps a pending-write scoreboard for decode.
module writeback_ctrl #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = writeback_ctrl_pkg::DATA_W,
  parameter int REG_W  = writeback_ctrl_pkg::REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_W-1:0]  lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              issue_en,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  output logic              busy_rs,
  output logic              busy_rt,
  output logic              RegWrite,
  output logic [REG_W-1:0]  WriteRegister,
  output logic [DATA_W-1:0] WriteData
);

  import writeback_ctrl_pkg::*;

  localparam int N_REGS = 1 << REG_W;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  wb_entry_t          w_push_entry;
  wb_entry_t          w_head;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  logic               w_alu_win;
  logic               w_pop;
  logic               w_push;
  logic [N_REGS-1:0]  w_sb_next;

  logic               r_src_fifo;
  logic [N_REGS-1:0]  r_sb;

  assign w_push_entry = '{rd: lsu_rd, data: lsu_data};
  assign lsu_ready    = !w_full;
  assign w_push       = lsu_valid && lsu_ready;

  // An ALU write to r0 is discarded, so it must not steal the port from the FIFO.
  assign w_alu_win = alu_valid && (alu_rd != '0);
  assign w_pop     = !w_alu_win && !w_empty;

  wb_fifo #(
    .DEPTH (DEPTH),
    .T     (wb_entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      r_src_fifo    <= 1'b0;
    end else if (w_alu_win) begin
      RegWrite      <= 1'b1;
      WriteRegister <= alu_rd;
      WriteData     <= alu_data;
      r_src_fifo    <= 1'b0;
    end else if (w_pop) begin
      RegWrite      <= (w_head.rd != '0);
      WriteRegister <= w_head.rd;
      WriteData     <= w_head.data;
      r_src_fifo    <= 1'b1;
    end else begin
      RegWrite      <= 1'b0;
      r_src_fifo    <= 1'b0;
    end
  end

  // NOTE: every combinational output gets a default first, otherwise the
  // untouched bits would infer latches.
  always_comb begin
    w_sb_next = r_sb;
    // The clear is the commit that just happened; a new reservation on the
    // same register is applied afterwards so it wins.
    if (RegWrite && r_src_fifo) w_sb_next[WriteRegister] = 1'b0;
    if (issue_en && (issue_rd != '0)) w_sb_next[issue_rd] = 1'b1;
    w_sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sb <= '0;
    else       r_sb <= w_sb_next;
  end

  assign busy_rs = r_sb[rs];
  assign busy_rt = r_sb[rt];

  a_count_range: assert property (@(posedge clk) disable iff (reset)
    (w_count <= CNT_W'(DEPTH)) && (w_full == (w_count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_writeback_ctrl.sv
// Randomised + directed bench for writeback_ctrl with a queue-based reference
// model and a scoreboard monitor checking the register-file write port.
module tb_writeback_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        busy_rs;
  logic        busy_rt;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;

  writeback_ctrl #(.DEPTH(DEPTH), .DATA_W(32), .REG_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .lsu_valid     (lsu_valid),
    .lsu_ready     (lsu_ready),
    .lsu_rd        (lsu_rd),
    .lsu_data      (lsu_data),
    .issue_en      (issue_en),
    .issue_rd      (issue_rd),
    .rs            (rs),
    .rt            (rt),
    .busy_rs       (busy_rs),
    .busy_rt       (busy_rt),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  // Reference model state: pending long-latency results, reservations,
  // the commit whose clear lands on the next edge, and the held port values.
  ent_t        m_q[$];
  bit   [31:0] m_sb;
  bit          m_clr_v;
  logic [4:0]  m_clr_rd;
  logic [4:0]  m_last_rd;
  logic [31:0] m_last_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_sb        = '0;
    m_clr_v     = 1'b0;
    m_clr_rd    = '0;
    m_last_rd   = '0;
    m_last_data = '0;
    exp_q.delete();
  endtask

  task automatic set_idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_en  = 0; issue_rd = 0;
  endtask

  // One clock of stimulus: drive, check combinational outputs, advance model.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic ie, input logic [4:0] ird,
                      input logic [4:0] s1, input logic [4:0] s2);
    exp_t e;
    ent_t ent;
    bit   src;
    int   sz;
    @(negedge clk);
    #1;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    issue_en  = ie; issue_rd = ird;
    rs = s1; rt = s2;
    #1;
    sz = m_q.size();
    check("lsu_ready", 64'(lsu_ready), 64'(sz < DEPTH));
    check("busy_rs", 64'(busy_rs), 64'(m_sb[s1]));
    check("busy_rt", 64'(busy_rt), 64'(m_sb[s2]));

    src    = 1'b0;
    e.we   = 1'b0;
    e.rd   = m_last_rd;
    e.data = m_last_data;
    if (av && ard != 0) begin
      e.we = 1'b1; e.rd = ard; e.data = ad;
    end else if (sz > 0) begin
      ent    = m_q.pop_front();
      e.we   = (ent.rd != 0);
      e.rd   = ent.rd;
      e.data = ent.data;
      src    = 1'b1;
    end
    m_last_rd   = e.rd;
    m_last_data = e.data;

    if (m_clr_v) m_sb[m_clr_rd] = 1'b0;
    if (ie && ird != 0) m_sb[ird] = 1'b1;
    m_clr_v  = e.we && src;
    m_clr_rd = e.rd;

    if (lv && sz < DEPTH) m_q.push_back('{rd: lrd, data: ld});
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    step(0, 0, 0, 0, 0, 0, 0, 0, s1, s2);
  endtask

  // Monitor: each negedge compares the port against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("RegWrite", 64'(RegWrite), 64'(e.we));
        check("WriteRegister", 64'(WriteRegister), 64'(e.rd));
        check("WriteData", 64'(WriteData), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    set_idle();
    rs = 0; rt = 0;
    model_reset();
    #22;
    reset = 1'b0;
    #1;
    check("reset RegWrite", 64'(RegWrite), 64'(0));
    check("reset WriteRegister", 64'(WriteRegister), 64'(0));
    check("reset WriteData", 64'(WriteData), 64'(0));
    check("reset lsu_ready", 64'(lsu_ready), 64'(1));

    // ALU only, including a write to r0
    step(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 3, 0);
    idle(0, 0);
    step(1, 0, 32'h55555555, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0);

    // Long-latency path with reservation of r7
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    step(0, 0, 0, 1, 7, 32'h1234, 0, 0, 7, 7);
    for (int i = 0; i < 3; i++) idle(7, 7);

    // Contention: ALU writes 1,2,4 hold off the pending write of r9
    step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    step(1, 1, 32'h11, 1, 9, 32'hA, 0, 0, 9, 0);
    step(1, 2, 32'h22, 0, 0, 0, 0, 0, 9, 0);
    step(1, 4, 32'h44, 0, 0, 0, 0, 0, 9, 0);
    for (int i = 0; i < 3; i++) idle(9, 0);

    // Full FIFO while ALU holds the port, then drain (pointers wrap)
    for (int i = 0; i < DEPTH; i++)
      step(1, 5'(20 + i), 32'(i), 1, 5'(10 + i), 32'(32'hF00 + i), 1, 5'(10 + i), 5'(10 + i), 0);
    step(1, 30, 32'h30, 1, 15, 32'hBAD, 0, 0, 10, 11);
    check("full lsu_ready", 64'(lsu_ready), 64'(0));
    for (int i = 0; i < DEPTH + 2; i++) idle(5'(10 + i), 13);

    // Scoreboard collision on r12 plus reservation of r0
    step(0, 0, 0, 0, 0, 0, 1, 12, 12, 0);
    step(0, 0, 0, 1, 12, 32'hC0C0, 0, 0, 12, 0);
    idle(12, 0);
    step(0, 0, 0, 0, 0, 0, 1, 12, 12, 0);
    idle(12, 0);
    check("collision busy r12", 64'(busy_rs), 64'(1));
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(0, 12);
    check("busy r0", 64'(busy_rs), 64'(0));
    // FIFO entry addressed to r0 is consumed silently
    step(0, 0, 0, 1, 0, 32'h77, 0, 0, 0, 0);
    idle(0, 0);
    idle(0, 0);

    // Reset mid-stream: 3 queued entries and r5 reserved
    step(0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
    step(1, 1, 32'h1, 1, 5, 32'h501, 0, 0, 5, 0);
    step(1, 2, 32'h2, 1, 6, 32'h601, 0, 0, 5, 0);
    step(1, 3, 32'h3, 1, 8, 32'h801, 0, 0, 5, 0);
    @(negedge clk);
    #3;
    set_idle();
    rs = 5;
    reset = 1'b1;
    #1;
    check("midreset RegWrite", 64'(RegWrite), 64'(0));
    check("midreset lsu_ready", 64'(lsu_ready), 64'(1));
    check("midreset busy r5", 64'(busy_rs), 64'(0));
    model_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) idle(5, 6);

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 2) == 0, 5'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 3) == 0, 5'($urandom_range(0, 15)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 15)));
    end
    for (int i = 0; i < DEPTH + 3; i++) idle(0, 0);

    @(negedge clk);
    #2;
    check("scoreboard drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
